// File: rtl/turn_sequencer_m.sv
// Turn sequencer for a 3x3 board: arbitrates X/O move requests, owns the board write
// port and decides win/draw/next turn. Optional per-move forfeit timer: MOVE_TIMEOUT_EN.
module turn_sequencer_m #(
   parameter int CELLS       = 9,
   parameter int IDX_W       = 4,
   parameter int FIRST_O     = 0,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               new_game,
   input  logic               x_req,
   input  logic [IDX_W-1:0]   x_loc,
   output logic               x_ack,
   output logic               x_nack,
   input  logic               o_req,
   input  logic [IDX_W-1:0]   o_loc,
   output logic               o_ack,
   output logic               o_nack,
   input  logic [2*CELLS-1:0] board_state,
   output logic               wr_en,
   output logic [IDX_W-1:0]   wr_loc,
   output logic [1:0]         wr_val,
   output logic               board_clr,
   output logic               turn,
   output logic               game_over,
   output logic [1:0]         winner
);

   typedef enum logic [1:0] {
      S_WAIT,
      S_WRITE,
      S_CHECK,
      S_OVER
   } state_t;

   state_t state;

   // Out-of-range indices read as the illegal code so they can never look empty.
   function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b,
                                          input logic [IDX_W-1:0]   loc);
      logic [1:0] c;
      c = 2'b11;
      for (int i = 0; i < CELLS; i++) begin
         if (loc == IDX_W'(i)) c = b[2*i +: 2];
      end
      return c;
   endfunction

   function automatic logic is_legal(input logic [2*CELLS-1:0] b,
                                     input logic [IDX_W-1:0]   loc);
      return (int'(loc) < CELLS) && (cell_at(b, loc) == 2'b00);
   endfunction

   function automatic logic line3(input logic [2*CELLS-1:0] b,
                                  input int a, input int c, input int d,
                                  input logic [1:0] v);
      return (b[2*a +: 2] == v) && (b[2*c +: 2] == v) && (b[2*d +: 2] == v);
   endfunction

   function automatic logic has_line(input logic [2*CELLS-1:0] b,
                                     input logic [1:0]         v);
      return line3(b, 0, 1, 2, v) || line3(b, 3, 4, 5, v) || line3(b, 6, 7, 8, v) ||
             line3(b, 0, 3, 6, v) || line3(b, 1, 4, 7, v) || line3(b, 2, 5, 8, v) ||
             line3(b, 0, 4, 8, v) || line3(b, 2, 4, 6, v);
   endfunction

   function automatic logic board_full(input logic [2*CELLS-1:0] b);
      logic f;
      f = 1'b1;
      for (int i = 0; i < CELLS; i++) begin
         if (b[2*i +: 2] == 2'b00) f = 1'b0;
      end
      return f;
   endfunction

   logic             act_req;
   logic [IDX_W-1:0] act_loc;
   logic [1:0]       side_val;
   logic             nack_hold;
   logic             act_legal;

   assign act_req   = turn ? o_req : x_req;
   assign act_loc   = turn ? o_loc : x_loc;
   assign side_val  = turn ? 2'b10 : 2'b01;
   // A requester sees its nack one cycle late, so its still-high req is skipped once.
   assign nack_hold = x_nack | o_nack;
   assign act_legal = is_legal(board_state, act_loc);

`ifdef MOVE_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;

   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_WAIT;
         turn      <= (FIRST_O != 0);
         game_over <= 1'b0;
         winner    <= 2'b00;
         x_ack     <= 1'b0;
         x_nack    <= 1'b0;
         o_ack     <= 1'b0;
         o_nack    <= 1'b0;
         wr_en     <= 1'b0;
         wr_loc    <= '0;
         wr_val    <= 2'b00;
         board_clr <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
         wait_cnt  <= '0;
`endif
      end else begin
         x_ack     <= 1'b0;
         x_nack    <= 1'b0;
         o_ack     <= 1'b0;
         o_nack    <= 1'b0;
         wr_en     <= 1'b0;
         board_clr <= 1'b0;
         if (new_game) begin
            board_clr <= 1'b1;
            turn      <= (FIRST_O != 0);
            game_over <= 1'b0;
            winner    <= 2'b00;
            state     <= S_WAIT;
`ifdef MOVE_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
         end else begin
            case (state)
               S_WAIT: begin
`ifdef MOVE_TIMEOUT_EN
                  wait_cnt <= wait_cnt + 1'b1;
`endif
                  if (act_req && !nack_hold && act_legal) begin
                     if (turn) o_ack <= 1'b1;
                     else      x_ack <= 1'b1;
                     wr_en  <= 1'b1;
                     wr_loc <= act_loc;
                     wr_val <= side_val;
                     state  <= S_WRITE;
                  end else begin
                     if (act_req && !nack_hold) begin
                        if (turn) o_nack <= 1'b1;
                        else      x_nack <= 1'b1;
                     end
`ifdef MOVE_TIMEOUT_EN
                     if (timeout_hit) begin
                        game_over <= 1'b1;
                        winner    <= turn ? 2'b01 : 2'b10;
                        state     <= S_OVER;
                     end
`endif
                  end
               end
               // board_m commits on the edge leaving WRITE; CHECK sees the new board.
               S_WRITE: state <= S_CHECK;
               S_CHECK: begin
                  if (has_line(board_state, side_val)) begin
                     game_over <= 1'b1;
                     winner    <= side_val;
                     state     <= S_OVER;
                  end else if (board_full(board_state)) begin
                     game_over <= 1'b1;
                     winner    <= 2'b00;
                     state     <= S_OVER;
                  end else begin
                     turn  <= ~turn;
                     state <= S_WAIT;
`ifdef MOVE_TIMEOUT_EN
                     wait_cnt <= '0;
`endif
                  end
               end
               S_OVER:  state <= S_OVER;
               default: state <= S_WAIT;
            endcase
         end
      end
   end

endmodule
